reg_bank_sweep: RTL and testbench

Parametrised register bank of DEPTH entries × WIDTH bits: one write port, two independent registered read ports with true and complement outputs, and a sequenced clear engine that zeroes the bank one entry per cycle. It generalises our single 4-bit enabled flip-flop into addressable storage for the memory subsystem. Its clean per-edge behaviour makes it the base for later FIFO and cache-tag blocks.

---
 rtl/reg_bank_sweep.sv | 134 +++++++++++++
 tb/tb_reg_bank_sweep.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_sweep.sv
// Addressable WIDTH x DEPTH register bank with one write port, two registered
// read ports (true + complement) and a one-entry-per-cycle clear sweep.
module reg_bank_sweep #(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  output logic             wr_drop,
  input  logic             re_a,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_a_n,
  input  logic             re_b,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  output logic [WIDTH-1:0] rdata_b_n,
  input  logic             clr,
  output logic             busy
);

  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] rdata_a_q, rdata_a_d;
  logic [WIDTH-1:0] rdata_a_n_q, rdata_a_n_d;
  logic [WIDTH-1:0] rdata_b_q, rdata_b_d;
  logic [WIDTH-1:0] rdata_b_n_q, rdata_b_n_d;
  logic             wr_drop_q, wr_drop_d;

  logic             wr_ok;
  logic [WIDTH-1:0] rd_a, rd_b;

  // Reads see the array as it was before this edge, except that an accepted
  // same-edge write to the same address is forwarded; addresses past the end
  // read as zero.
  function automatic logic [WIDTH-1:0] port_read(input logic [AW-1:0] ra,
                                                 input logic          fwd,
                                                 input logic [AW-1:0] wa,
                                                 input logic [WIDTH-1:0] wd);
    logic [WIDTH-1:0] v;
    v = '0;
    if ({1'b0, ra} < DEPTH_W) begin
      if (fwd && (wa == ra)) v = wd;
      else                   v = mem_q[ra];
    end
    return v;
  endfunction

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    mem_d   = mem_q;

    wr_ok     = we && (state_q == ST_IDLE) && !clr && ({1'b0, waddr} < DEPTH_W);
    wr_drop_d = we && !wr_ok;

    rd_a = port_read(raddr_a, wr_ok, waddr, wdata);
    rd_b = port_read(raddr_b, wr_ok, waddr, wdata);

    rdata_a_d   = re_a ? rd_a  : rdata_a_q;
    rdata_a_n_d = re_a ? ~rd_a : rdata_a_n_q;
    rdata_b_d   = re_b ? rd_b  : rdata_b_q;
    rdata_b_n_d = re_b ? ~rd_b : rdata_b_n_q;

    if (wr_ok) mem_d[waddr] = wdata;

    unique case (state_q)
      ST_IDLE: begin
        if (clr) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      ST_CLEAR: begin
        mem_d[ptr_q] = '0;
        if (ptr_q == LAST) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + AW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // Register stage: array, read outputs and control all reset asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      wr_drop_q   <= 1'b0;
      rdata_a_q   <= '0;
      rdata_a_n_q <= '1;
      rdata_b_q   <= '0;
      rdata_b_n_q <= '1;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      wr_drop_q   <= wr_drop_d;
      rdata_a_q   <= rdata_a_d;
      rdata_a_n_q <= rdata_a_n_d;
      rdata_b_q   <= rdata_b_d;
      rdata_b_n_q <= rdata_b_n_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign wr_drop   = wr_drop_q;
  assign rdata_a   = rdata_a_q;
  assign rdata_a_n = rdata_a_n_q;
  assign rdata_b   = rdata_b_q;
  assign rdata_b_n = rdata_b_n_q;
  assign busy      = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_reg_bank_sweep.sv
// Bench for reg_bank_sweep: directed steps plus random traffic against a
// behavioural model of the bank (DEPTH=8), and directed out-of-range checks on a DEPTH=6 copy.
module tb_reg_bank_sweep;

  localparam int D = 8;

  logic       clk = 1'b0;
  logic       reset;
  always #5 clk = ~clk;

  logic       we, re_a, re_b, clr;
  logic [2:0] waddr, raddr_a, raddr_b;
  logic [3:0] wdata;
  logic       wr_drop, busy;
  logic [3:0] rdata_a, rdata_a_n, rdata_b, rdata_b_n;

  logic       we6, re_a6, re_b6, clr6;
  logic [2:0] waddr6, raddr_a6, raddr_b6;
  logic [3:0] wdata6;
  logic       wr_drop6, busy6;
  logic [3:0] rdata_a6, rdata_a_n6, rdata_b6, rdata_b_n6;

  reg_bank_sweep #(.WIDTH(4), .DEPTH(8)) dut (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .wr_drop(wr_drop), .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a),
    .rdata_a_n(rdata_a_n), .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b),
    .rdata_b_n(rdata_b_n), .clr(clr), .busy(busy)
  );

  reg_bank_sweep #(.WIDTH(4), .DEPTH(6)) dut6 (
    .clk(clk), .reset(reset), .we(we6), .waddr(waddr6), .wdata(wdata6),
    .wr_drop(wr_drop6), .re_a(re_a6), .raddr_a(raddr_a6), .rdata_a(rdata_a6),
    .rdata_a_n(rdata_a_n6), .re_b(re_b6), .raddr_b(raddr_b6), .rdata_b(rdata_b6),
    .rdata_b_n(rdata_b_n6), .clr(clr6), .busy(busy6)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: contents, read registers, and how many entries the
  // current sweep still has to clear (0 means no sweep running).
  logic [3:0] m_mem [D];
  logic [3:0] m_ra, m_rb;
  logic       m_drop;
  int         m_left;

  task automatic model_reset();
    for (int i = 0; i < D; i++) m_mem[i] = 4'h0;
    m_ra = 4'h0; m_rb = 4'h0; m_drop = 1'b0; m_left = 0;
  endtask

  task automatic model_edge();
    bit         accept;
    logic [3:0] va, vb;
    accept = we && (m_left == 0) && !clr;
    va = (accept && waddr == raddr_a) ? wdata : m_mem[raddr_a];
    vb = (accept && waddr == raddr_b) ? wdata : m_mem[raddr_b];
    if (re_a) m_ra = va;
    if (re_b) m_rb = vb;
    m_drop = we && !accept;
    if (accept) m_mem[waddr] = wdata;
    if (m_left > 0) begin
      m_mem[D - m_left] = 4'h0;
      m_left--;
    end else if (clr) begin
      m_left = D;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    logic [3:0] na, nb;
    na = ~m_ra;
    nb = ~m_rb;
    chk("rdata_a", rdata_a, m_ra);
    chk("rdata_a_n", rdata_a_n, na);
    chk("rdata_b", rdata_b, m_rb);
    chk("rdata_b_n", rdata_b_n, nb);
    chk("wr_drop", wr_drop, m_drop);
    chk("busy", busy, (m_left > 0));
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    chk_all();
  endtask

  task automatic idle_inputs();
    we = 0; re_a = 0; re_b = 0; clr = 0;
    waddr = 0; raddr_a = 0; raddr_b = 0; wdata = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    idle_inputs();
    we6 = 0; re_a6 = 0; re_b6 = 0; clr6 = 0;
    waddr6 = 0; raddr_a6 = 0; raddr_b6 = 0; wdata6 = 0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_all();

    // Write 0xA to 3, then read 3 on A and 0 on B.
    we = 1; waddr = 3; wdata = 4'hA;
    cyc();
    idle_inputs();
    re_a = 1; raddr_a = 3; re_b = 1; raddr_b = 0;
    cyc();
    chk("wr_rd_a", rdata_a, 4'hA);
    chk("wr_rd_a_n", rdata_a_n, 4'h5);
    chk("wr_rd_b", rdata_b, 4'h0);
    idle_inputs();
    raddr_a = 0;
    cyc();
    chk("hold_a", rdata_a, 4'hA);

    // Same-edge write and read of address 5.
    we = 1; waddr = 5; wdata = 4'h6; re_a = 1; raddr_a = 5;
    cyc();
    chk("bypass_a", rdata_a, 4'h6);
    idle_inputs();

    // Asynchronous reset between edges.
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("async_rst_a", rdata_a, 4'h0);
    chk("async_rst_a_n", rdata_a_n, 4'hF);
    chk("async_rst_b", rdata_b, 4'h0);
    chk("async_rst_b_n", rdata_b_n, 4'hF);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_drop", wr_drop, 1'b0);
    #2 reset = 1'b0;

    // Fill 1..8 and sweep.
    for (int i = 0; i < D; i++) begin
      we = 1; waddr = 3'(i); wdata = 4'(i + 1);
      cyc();
    end
    hi = 0;
    for (int k = 0; k <= 9; k++) begin
      idle_inputs();
      clr = (k == 0);
      if (k == 3) begin we = 1; waddr = 4; wdata = 4'h5; end
      if (k == 4) begin re_a = 1; raddr_a = 7; re_b = 1; raddr_b = 2; end
      cyc();
      if (busy) hi++;
      if (k == 3) chk("sweep_drop", wr_drop, 1'b1);
      if (k == 4) begin
        chk("sweep_unswept", rdata_a, 4'h8);
        chk("sweep_swept", rdata_b, 4'h0);
      end
    end
    chk("busy_cycles", hi, 8);
    for (int i = 0; i < D; i++) begin
      idle_inputs();
      re_a = 1; raddr_a = 3'(i);
      cyc();
      chk("after_sweep", rdata_a, 4'h0);
    end

    // clr and write on the same edge.
    idle_inputs();
    we = 1; waddr = 1; wdata = 4'h3;
    cyc();
    we = 1; waddr = 1; wdata = 4'hF; clr = 1;
    cyc();
    chk("clr_vs_we_drop", wr_drop, 1'b1);
    idle_inputs();
    repeat (D) cyc();
    re_a = 1; raddr_a = 1;
    cyc();
    chk("clr_vs_we_entry", rdata_a, 4'h0);
    chk("clr_vs_we_busy", busy, 1'b0);

    // Out-of-range accesses on the DEPTH=6 copy.
    idle_inputs();
    we6 = 1; waddr6 = 7; wdata6 = 4'h3;
    cyc();
    chk("oor_wr_drop6", wr_drop6, 1'b1);
    we6 = 1; waddr6 = 5; wdata6 = 4'h9;
    re_a6 = 1; raddr_a6 = 7; re_b6 = 1; raddr_b6 = 5;
    cyc();
    chk("inr_wr_drop6", wr_drop6, 1'b0);
    chk("oor_rd6", rdata_a6, 4'h0);
    chk("oor_rd_n6", rdata_a_n6, 4'hF);
    chk("bypass_b6", rdata_b6, 4'h9);
    chk("bypass_b_n6", rdata_b_n6, 4'h6);
    we6 = 0; re_a6 = 0; re_b6 = 0;

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      we      = 1'($urandom_range(0, 1));
      waddr   = 3'($urandom);
      wdata   = 4'($urandom);
      re_a    = 1'($urandom_range(0, 1));
      raddr_a = 3'($urandom);
      re_b    = 1'($urandom_range(0, 1));
      raddr_b = 3'($urandom);
      clr     = ($urandom_range(0, 24) == 0);
      cyc();
    end

    // Let any sweep finish, then load data and reset part-way through a sweep.
    idle_inputs();
    repeat (D + 1) cyc();
    for (int i = 0; i < D; i++) begin
      we = 1; waddr = 3'(i); wdata = 4'hF - 4'(i);
      cyc();
    end
    idle_inputs();
    clr = 1;
    cyc();
    clr = 0;
    repeat (3) cyc();
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("midsweep_busy", busy, 1'b0);
    chk_all();
    #2 reset = 1'b0;
    we = 1; waddr = 6; wdata = 4'hC;
    cyc();
    idle_inputs();
    re_a = 1; raddr_a = 6;
    cyc();
    chk("post_rst_wr_rd", rdata_a, 4'hC);
    for (int i = 0; i < D; i++) begin
      idle_inputs();
      re_b = 1; raddr_b = 3'(i);
      cyc();
    end

    // clr held across reset deassertion starts a sweep on the first edge.
    idle_inputs();
    #2 reset = 1'b1;
    clr = 1;
    #1;
    model_reset();
    #2 reset = 1'b0;
    cyc();
    chk("clr_after_rst", busy, 1'b1);
    idle_inputs();
    repeat (D + 1) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
